// File: rtl/tnn_feeder_pkg.sv
// Shared types, default widths, threshold table and quantizer for the TNN
// feature feeder. Optional feature macro: TNN_FEEDER_THRESH_EN selects the
// per-feature threshold quantizer; when undefined, plain truncation is used.
package tnn_feeder_pkg;

    localparam int DEF_IN_W   = 8;
    localparam int DEF_Q_W    = 3;
    localparam int DEF_N_FEAT = 5;
    localparam int DEF_TAG_W  = 16;
    localparam int DEF_IDX_W  = 3;
    localparam int N_THRESH   = 7;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        HOLD    = 2'd2
    } feeder_state_t;

    typedef logic [0:N_THRESH-1][DEF_IN_W-1:0] thresh_row_t;
    typedef thresh_row_t [0:DEF_N_FEAT-1]      thresh_tab_t;

    // Ascending thresholds per feature; a sample's level is how many it reaches.
    localparam thresh_tab_t THRESH = '{
        '{8'd16, 8'd32, 8'd48,  8'd64,  8'd80,  8'd96,  8'd112},
        '{8'd20, 8'd40, 8'd60,  8'd80,  8'd100, 8'd120, 8'd140},
        '{8'd8,  8'd24, 8'd48,  8'd80,  8'd120, 8'd168, 8'd224},
        '{8'd32, 8'd64, 8'd96,  8'd128, 8'd160, 8'd192, 8'd224},
        '{8'd10, 8'd30, 8'd60,  8'd100, 8'd150, 8'd200, 8'd250}
    };

    function automatic logic [DEF_Q_W-1:0] quantize(
        input logic [DEF_IDX_W-1:0] feature_idx,
        input logic [DEF_IN_W-1:0]  value
    );
`ifdef TNN_FEEDER_THRESH_EN
        logic [DEF_Q_W-1:0] count;
        count = '0;
        if (feature_idx < DEF_IDX_W'(DEF_N_FEAT)) begin
            for (int k = 0; k < N_THRESH; k++) begin
                if (THRESH[feature_idx][k] <= value) begin
                    count = count + DEF_Q_W'(1);
                end
            end
        end
        return count;
`else
        logic unused_idx;
        unused_idx = |feature_idx;
        return value[DEF_IN_W-1 -: DEF_Q_W];
`endif
    endfunction

endpackage

// File: rtl/tnn_feeder_quant.sv
// Combinational quantizer for the sample currently being collected.
// The mapping (truncation or threshold table) follows TNN_FEEDER_THRESH_EN.
module tnn_feeder_quant
    import tnn_feeder_pkg::*;
(
    input  logic [DEF_IDX_W-1:0] feat_idx,
    input  logic [DEF_IN_W-1:0]  value,
    output logic [DEF_Q_W-1:0]   q
);

    // Map the raw sample to its quantized level for the slot it will fill.
    always_comb begin
        q = quantize(feat_idx, value);
    end

endmodule

// File: rtl/tnn_feature_feeder.sv
// Stream front end for the 5-input TNN classifier: gathers quantized samples
// into a held feature vector, samples the classifier decision and returns it
// tagged on a result stream. Optional macro: TNN_FEEDER_THRESH_EN (threshold
// quantizer instead of truncation, see tnn_feeder_pkg).
module tnn_feature_feeder
    import tnn_feeder_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int Q_W    = DEF_Q_W,
    parameter int N_FEAT = DEF_N_FEAT,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_last,
    output logic [Q_W-1:0]   cls_a,
    output logic [Q_W-1:0]   cls_b,
    output logic [Q_W-1:0]   cls_c,
    output logic [Q_W-1:0]   cls_d,
    output logic [Q_W-1:0]   cls_e,
    input  logic             cls_y,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_data,
    output logic [TAG_W-1:0] m_tag,
    output logic [7:0]       err_cnt
);

    localparam int IDX_W = DEF_IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    feeder_state_t    state_q;
    feeder_state_t    state_d;
    logic [IDX_W-1:0] idx;
    logic [Q_W-1:0]   slot [N_FEAT];
    logic [Q_W-1:0]   q_sample;
    logic             s_hs;

    assign s_hs  = s_valid && s_ready;
    assign cls_a = slot[0];
    assign cls_b = slot[1];
    assign cls_c = slot[2];
    assign cls_d = slot[3];
    assign cls_e = slot[4];

    tnn_feeder_quant u_quant (
        .feat_idx (idx),
        .value    (s_data),
        .q        (q_sample)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: evaluate after the final slot fills, hold until the result is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (s_hs && idx == LAST_IDX) state_d = EVAL;
            EVAL:    state_d = HOLD;
            HOLD:    if (m_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Handshake outputs decoded from the registered state only.
    always_comb begin
        s_ready = rst_n && (state_q == COLLECT);
        m_valid = (state_q == HOLD);
    end

    // Slot filling and framing-error accounting; early s_last drops the partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            err_cnt <= '0;
            for (int i = 0; i < N_FEAT; i++) begin
                slot[i] <= '0;
            end
        end else if (s_hs) begin
            if (idx == LAST_IDX) begin
                slot[idx] <= q_sample;
                idx       <= '0;
                if (!s_last && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (s_last) begin
                idx <= '0;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else begin
                slot[idx] <= q_sample;
                idx       <= idx + IDX_W'(1);
            end
        end
    end

    // Capture the decision during EVAL and advance the tag when a result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= 1'b0;
            m_tag  <= '0;
        end else begin
            if (state_q == EVAL) begin
                m_data <= cls_y;
            end
            if (state_q == HOLD && m_ready) begin
                m_tag <= m_tag + TAG_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tnn_feature_feeder.sv
// Self-checking bench for tnn_feature_feeder: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model. Tag width is reduced so tag wrap-around is reachable.
module tb_tnn_feature_feeder;
    import tnn_feeder_pkg::*;

    localparam int TB_TAG_W = 6;
    localparam int NF = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                s_valid;
    logic                s_ready;
    logic [7:0]          s_data;
    logic                s_last;
    logic [2:0]          cls_a, cls_b, cls_c, cls_d, cls_e;
    logic                cls_y;
    logic                m_valid;
    logic                m_ready;
    logic                m_data;
    logic [TB_TAG_W-1:0] m_tag;
    logic [7:0]          err_cnt;

    int checks = 0;
    int passed = 0;
    int y_mode = 0;
    int mready_mode = 0;
    bit cadence_on = 0;
    int cycle = 0;
    int last_rise = -1;

    // Behavioural model state
    int mdl_cnt;
    int mdl_part [NF];
    int mdl_out [NF];
    bit mdl_eval;
    bit mdl_hold;
    bit prev_hold;
    int mdl_err;
    int mdl_tag;
    int mdl_data;

    tnn_feature_feeder #(
        .IN_W   (8),
        .Q_W    (3),
        .N_FEAT (5),
        .TAG_W  (TB_TAG_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .cls_a   (cls_a),
        .cls_b   (cls_b),
        .cls_c   (cls_c),
        .cls_d   (cls_d),
        .cls_e   (cls_e),
        .cls_y   (cls_y),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_tag   (m_tag),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic int decide(int mode, int a, int b, int c, int d, int e);
        if (mode == 0) return (a == 7) ? 1 : 0;
        return (((a + b + c + d + e) % 3) == 0) ? 1 : 0;
    endfunction

    function automatic int model_q(int f, int v);
`ifdef TNN_FEEDER_THRESH_EN
        int c = 0;
        for (int k = 0; k < 7; k++) begin
            if (int'(THRESH[f][k]) <= v) c++;
        end
        return c;
`else
        if (f < 0) return 0;
        return v / 32;
`endif
    endfunction

    // Stand-in classifier driven by the feeder's held features.
    always_comb begin
        cls_y = decide(y_mode, int'(cls_a), int'(cls_b), int'(cls_c),
                       int'(cls_d), int'(cls_e)) != 0;
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: accepted features, evaluation delay, pending result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt  = 0;
            mdl_eval = 0;
            mdl_hold = 0;
            mdl_err  = 0;
            mdl_tag  = 0;
            mdl_data = 0;
            for (int i = 0; i < NF; i++) begin
                mdl_part[i] = 0;
                mdl_out[i]  = 0;
            end
        end else if (mdl_hold) begin
            if (m_ready) begin
                mdl_hold = 0;
                mdl_tag  = (mdl_tag + 1) % (1 << TB_TAG_W);
            end
        end else if (mdl_eval) begin
            mdl_eval = 0;
            mdl_hold = 1;
            mdl_data = decide(y_mode, mdl_out[0], mdl_out[1], mdl_out[2],
                              mdl_out[3], mdl_out[4]);
        end else if (s_valid) begin
            if (mdl_cnt == NF - 1) begin
                mdl_part[mdl_cnt] = model_q(mdl_cnt, int'(s_data));
                mdl_out  = mdl_part;
                mdl_cnt  = 0;
                mdl_eval = 1;
                if (!s_last && mdl_err < 255) mdl_err++;
            end else if (s_last) begin
                mdl_cnt = 0;
                if (mdl_err < 255) mdl_err++;
            end else begin
                mdl_part[mdl_cnt] = model_q(mdl_cnt, int'(s_data));
                mdl_cnt++;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        cycle++;
        checkOutput("s_ready", 32'(s_ready), 32'(rst_n && !mdl_eval && !mdl_hold));
        checkOutput("m_valid", 32'(m_valid), 32'(mdl_hold));
        checkOutput("err_cnt", 32'(err_cnt), mdl_err);
        if (mdl_eval || mdl_hold || !rst_n) begin
            checkOutput("cls_a", 32'(cls_a), mdl_out[0]);
            checkOutput("cls_b", 32'(cls_b), mdl_out[1]);
            checkOutput("cls_c", 32'(cls_c), mdl_out[2]);
            checkOutput("cls_d", 32'(cls_d), mdl_out[3]);
            checkOutput("cls_e", 32'(cls_e), mdl_out[4]);
        end
        if (mdl_hold || !rst_n) begin
            checkOutput("m_data", 32'(m_data), mdl_data);
            checkOutput("m_tag", 32'(m_tag), mdl_tag);
        end
        if (!cadence_on) begin
            last_rise = -1;
        end else if (mdl_hold && !prev_hold) begin
            if (last_rise >= 0) checkOutput("cadence", cycle - last_rise, 7);
            last_rise = cycle;
        end
        prev_hold = mdl_hold;
    end

    // Result-side backpressure generator.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (mready_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 1) != 0);
            endcase
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic l);
        bit acc = 0;
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!acc && n < 100) begin
            acc = s_ready;
            @(posedge clk);
            #2;
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic sendVector(input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3,
                              input logic [7:0] d4, input logic l4);
        applyStimulus(d0, 1'b0);
        applyStimulus(d1, 1'b0);
        applyStimulus(d2, 1'b0);
        applyStimulus(d3, 1'b0);
        applyStimulus(d4, l4);
        s_valid = 1'b0;
    endtask

    task automatic waitResult();
        int n = 0;
        while (!m_valid && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!m_valid) checkOutput("result_timeout", 0, 1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!s_ready && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!s_ready) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic drainResult();
        mready_mode = 1;
        waitIdle();
        mready_mode = 0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        $display("[TB] directed vector, truncation levels and latency");
        y_mode = 0;
        sendVector(8'hE0, 8'h40, 8'h9F, 8'h20, 8'h00, 1'b1);
        checkOutput("lat_eval_mvalid", 32'(m_valid), 0);
        @(posedge clk);
        #2;
        checkOutput("lat_hold_mvalid", 32'(m_valid), 1);
`ifndef TNN_FEEDER_THRESH_EN
        checkOutput("lit_cls_a", 32'(cls_a), 7);
        checkOutput("lit_cls_b", 32'(cls_b), 2);
        checkOutput("lit_cls_c", 32'(cls_c), 4);
        checkOutput("lit_cls_d", 32'(cls_d), 1);
        checkOutput("lit_cls_e", 32'(cls_e), 0);
        checkOutput("lit_m_data", 32'(m_data), 1);
`endif
        checkOutput("lit_m_tag0", 32'(m_tag), 0);
        drainResult();

        $display("[TB] early s_last then clean vector");
        doReset();
        y_mode = 1;
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h20, 1'b0);
        applyStimulus(8'h30, 1'b1);
        sendVector(8'hFF, 8'h60, 8'hA0, 8'h1F, 8'hC0, 1'b1);
        waitResult();
        checkOutput("early_err", 32'(err_cnt), 1);
        checkOutput("early_tag", 32'(m_tag), 0);
`ifndef TNN_FEEDER_THRESH_EN
        checkOutput("early_cls_a", 32'(cls_a), 7);
        checkOutput("early_cls_e", 32'(cls_e), 6);
        checkOutput("early_m_data", 32'(m_data), 1);
`endif
        drainResult();

        $display("[TB] missing s_last, then long backpressure in HOLD");
        doReset();
        sendVector(8'h11, 8'h52, 8'h93, 8'hD4, 8'hF5, 1'b0);
        waitResult();
        checkOutput("nolast_err", 32'(err_cnt), 1);
        repeat (10) @(posedge clk);
        #2;
        checkOutput("hold_s_ready", 32'(s_ready), 0);
        checkOutput("hold_m_valid", 32'(m_valid), 1);
        drainResult();

        $display("[TB] back-to-back vectors with tag wrap");
        doReset();
        mready_mode = 1;
        cadence_on  = 1;
        for (int v = 0; v < 70; v++) begin
            applyStimulus(8'($urandom), 1'b0);
            applyStimulus(8'($urandom), 1'b0);
            applyStimulus(8'($urandom), 1'b0);
            applyStimulus(8'($urandom), 1'b0);
            applyStimulus(8'($urandom), 1'b1);
        end
        s_valid = 1'b0;
        waitIdle();
        cadence_on = 0;
        checkOutput("tag_wrap", 32'(m_tag), 70 % 64);
        mready_mode = 0;

        $display("[TB] reset in the middle of a vector");
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        applyStimulus(8'hFF, 1'b0);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_s_ready", 32'(s_ready), 0);
        checkOutput("rst_err", 32'(err_cnt), 0);
        checkOutput("rst_cls_a", 32'(cls_a), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        sendVector(8'h00, 8'h20, 8'h40, 8'h60, 8'h80, 1'b1);
        waitResult();
        checkOutput("post_rst_tag", 32'(m_tag), 0);
`ifndef TNN_FEEDER_THRESH_EN
        checkOutput("post_rst_cls_a", 32'(cls_a), 0);
        checkOutput("post_rst_cls_c", 32'(cls_c), 2);
        checkOutput("post_rst_cls_e", 32'(cls_e), 4);
`endif
        drainResult();

        $display("[TB] quantizer level for value 50 on feature 0");
        sendVector(8'd50, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        waitResult();
`ifdef TNN_FEEDER_THRESH_EN
        checkOutput("quant_50", 32'(cls_a), 3);
`else
        checkOutput("quant_50", 32'(cls_a), 1);
`endif
        drainResult();

        $display("[TB] error counter saturation");
        doReset();
        for (int i = 0; i < 260; i++) begin
            applyStimulus(8'($urandom), 1'b1);
        end
        s_valid = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("err_sat", 32'(err_cnt), 255);

        $display("[TB] randomized traffic");
        doReset();
        mready_mode = 2;
        begin
            int pos = 0;
            for (int i = 0; i < 400; i++) begin
                logic l;
                if ($urandom_range(0, 3) == 0) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #2;
                end
                if (pos == NF - 1) l = ($urandom_range(0, 7) != 0);
                else               l = ($urandom_range(0, 11) == 0);
                applyStimulus(8'($urandom), l);
                pos = (l || pos == NF - 1) ? 0 : pos + 1;
            end
        end
        s_valid = 1'b0;
        mready_mode = 1;
        waitIdle();
        repeat (2) @(posedge clk);
        #2;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/tnn_feature_feeder.md
# tnn_feature_feeder

Stream-side front end for the evolved 5-input, 3-bit-feature, 1-bit-output TNN classifier cores. Accepts raw 8-bit feature samples one per cycle over a valid/ready stream. Quantizes each sample to 3 bits and assembles a 5-feature vector, which it holds stable on the classifier's parallel inputs. It then captures the classifier's combinational decision and returns it, tagged, on an output stream.

## Interface
Parameters:
- IN_W, 8, raw feature width
- Q_W, 3, quantized feature width (must match the classifier core)
- N_FEAT, 5, features per vector
- TAG_W, 16, result tag width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- s_valid  in  1  raw sample valid
- s_ready  out  1  feeder accepts a sample
- s_data  in  IN_W  raw feature value
- s_last  in  1  marks the final feature of a vector
- cls_a..cls_e  out  Q_W each  quantized features 0..4 to the classifier
- cls_y  in  1  classifier decision (combinational function of cls_a..cls_e)
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_data  out  1  captured decision
- m_tag  out  TAG_W  vector sequence number
- err_cnt  out  8  framing-error count, saturating

## Operation
- FSM states: COLLECT, EVAL, HOLD. Reset state is COLLECT.
- COLLECT:
  - s_ready=1.
  - On handshake, q(s_data) is written into slot idx (a 0..N_FEAT-1 counter), and idx increments.
  - Slot 0 drives cls_a, slot 1 cls_b, and so on.
- Early s_last (handshake with s_last=1 and idx<N_FEAT-1):
  - Partial vector is discarded and idx returns to 0.
  - err_cnt increments. State stays COLLECT.
- Handshake at idx=N_FEAT-1:
  - Slot is stored, idx returns to 0, and the FSM goes to EVAL.
  - If s_last=0, err_cnt increments, but the vector is still evaluated.
- EVAL:
  - s_ready=0.
  - cls_* are stable from registers; cls_y is registered into m_data at the end of the cycle.
  - FSM goes to HOLD.
- HOLD:
  - m_valid=1, s_ready=0.
  - On m_ready: m_tag increments (wraps from 0xFFFF to 0) and the FSM returns to COLLECT.
- Output stability:
  - cls_* change only on COLLECT handshakes; they are never altered during EVAL or HOLD.
  - m_data and m_tag are stable while m_valid=1 and m_ready=0.
- err_cnt saturates at 255.
- Reset mid-operation:
  - Partial vector and pending result are lost.
  - All outputs take their reset values.

## Timing
- Reset values: s_ready=0 while rst_n=0, then 1 in COLLECT; cls_*=0, m_valid=0, m_data=0, m_tag=0, err_cnt=0.
- s_ready and m_valid are decoded from the registered state, with no combinational path from s_valid or m_ready.
- Latency: m_valid rises 2 cycles after the handshake of the last feature (1 cycle EVAL, then registered into HOLD).
- Minimum period per vector: N_FEAT + 2 cycles, i.e. 7, with m_ready held high.
- The classifier path cls_* -> cls_y must settle within one cycle (EVAL).

## Configuration
- TNN_FEEDER_THRESH_EN defined:
  - q = number of entries in per-feature threshold table THRESH[f][0..6] that are ≤ s_data.
  - Thresholds are ascending, so q ranges 0..7.
- Undefined: q = s_data[IN_W-1 -: Q_W], i.e. plain truncation.

## Structure
- Package tnn_feeder_pkg holds:
  - state enum (COLLECT, EVAL, HOLD)
  - IN_W/Q_W/N_FEAT defaults
  - THRESH table type and contents
  - function quantize(feature_idx, value)
- One sub-module, tnn_feeder_quant: the combinational quantizer used in COLLECT, selected by the macro.

## Test plan
- Truncation build, send 0xE0,0x40,0x9F,0x20,0x00 with s_last on the fifth, cls_y tied to (cls_a==7) -> cls_a..e = 7,2,4,1,0; m_valid 2 cycles after last handshake; m_data=1, m_tag=0.
- s_last on the third sample, then a clean 5-sample vector -> err_cnt=1; only one result emitted, m_tag=0, carrying the second vector's features.
- Five samples with no s_last -> err_cnt=1; result still emitted.
- m_ready held low 10 cycles in HOLD -> s_ready=0 throughout; m_data and m_tag stable; cls_* unchanged.
- 65536 back-to-back vectors with m_ready=1 -> 7-cycle cadence; m_tag wraps from 0xFFFF to 0.
- rst_n asserted after 3 samples, then a full vector -> all outputs return to reset values; the next result has m_tag=0 and no stale slots.
- THRESH build with THRESH[0]={16,32,...,112} and s_data=50 -> cls_a=3.
